// File: rtl/uart_pkg.sv
// Shared UART constants, frame-time helper and pacer state encoding.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 10;
    localparam int DEF_CLK_FREQ    = 50_000_000;
    localparam int DEF_UART_BPS    = 9600;

    // Divide before multiplying so the result matches the uart_rx/uart_tx baud divider.
    function automatic int frame_clks(input int clk_freq, input int bps, input int bits);
        return (clk_freq / bps) * bits;
    endfunction

    typedef enum logic [1:0] {IDLE, SEND, WAIT} pacer_state_e;

endpackage

// File: rtl/uart_loop_buf_if.sv
// Byte stream and status bundle between uart_rx/uart_tx and the loopback buffer.
// UART_BUF_STATS_EN adds the rx_bytes/tx_bytes counters.
interface uart_loop_buf_if #(parameter int DEPTH = 16);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [7:0]       pi_data;
    logic             pi_flag;
    logic [7:0]       po_data;
    logic             po_flag;
    logic [CNT_W-1:0] fifo_cnt;
    logic             full;
    logic             empty;
    logic             ovf_err;
`ifdef UART_BUF_STATS_EN
    logic [15:0]      rx_bytes;
    logic [15:0]      tx_bytes;
`endif

`ifdef UART_BUF_STATS_EN
    modport master (output pi_data, pi_flag,
                    input  po_data, po_flag, fifo_cnt, full, empty, ovf_err, rx_bytes, tx_bytes);
    modport slave  (input  pi_data, pi_flag,
                    output po_data, po_flag, fifo_cnt, full, empty, ovf_err, rx_bytes, tx_bytes);
`else
    modport master (output pi_data, pi_flag,
                    input  po_data, po_flag, fifo_cnt, full, empty, ovf_err);
    modport slave  (input  pi_data, pi_flag,
                    output po_data, po_flag, fifo_cnt, full, empty, ovf_err);
`endif

endinterface

// File: rtl/uart_loop_buf_sync_fifo.sv
// Synchronous FIFO with explicit occupancy counter; head word is presented combinationally.
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ok,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_loop_buf.sv
// FIFO plus frame-time pacer feeding uart_tx at most one byte per UART frame.
// Define UART_BUF_STATS_EN to add rx_bytes/tx_bytes counters.
module uart_loop_buf
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int UART_BPS   = DEF_UART_BPS,
    parameter int FRAME_BITS = UART_FRAME_BITS
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    uart_loop_buf_if.slave bus
);

    localparam int FRAME_CLKS = frame_clks(CLK_FREQ, UART_BPS, FRAME_BITS);
    localparam int TMR_W      = $clog2(FRAME_CLKS) + 1;

    pacer_state_e            state, state_nxt;
    logic [TMR_W-1:0]        tmr;
    logic                    pop, wr_ok;
    logic [UART_DATA_W-1:0]  head;
    logic [$clog2(DEPTH):0]  cnt;
    logic                    full, empty;
    logic [UART_DATA_W-1:0]  po_data_q;
    logic                    po_flag_q, ovf_q;

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(UART_DATA_W)) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (bus.pi_flag),
        .wr_data (bus.pi_data),
        .wr_ok   (wr_ok),
        .rd_en   (pop),
        .rd_data (head),
        .cnt     (cnt),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = SEND;
            SEND:    state_nxt = WAIT;
            WAIT:    if (tmr == '0) state_nxt = empty ? IDLE : SEND;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop = (state == SEND);
    end

    // SEND plus FRAME_CLKS-1 WAIT cycles gives exactly FRAME_CLKS between pulses.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmr       <= '0;
            po_data_q <= '0;
            po_flag_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            po_flag_q <= pop;
            if (pop) begin
                po_data_q <= head;
                tmr       <= TMR_W'(FRAME_CLKS - 2);
            end else if (state == WAIT && tmr != '0) begin
                tmr <= tmr - 1'b1;
            end
            if (bus.pi_flag && !wr_ok) ovf_q <= 1'b1;
        end
    end

    assign bus.po_data  = po_data_q;
    assign bus.po_flag  = po_flag_q;
    assign bus.fifo_cnt = cnt;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.ovf_err  = ovf_q;

`ifdef UART_BUF_STATS_EN
    logic [15:0] rx_q, tx_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_q <= '0;
            tx_q <= '0;
        end else begin
            if (wr_ok) rx_q <= rx_q + 16'd1;
            if (pop)   tx_q <= tx_q + 16'd1;
        end
    end

    assign bus.rx_bytes = rx_q;
    assign bus.tx_bytes = tx_q;
`endif

endmodule
